// File: rtl/dcache_wb_buffer_pkg.sv
// Shared definitions for the dcache write-back buffer: widths, drain FSM states
// and a small state-classification helper.
package dcache_wb_buffer_pkg;

    localparam int REG_LEN      = 32;
    localparam int DM_UNIT_MASK = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } wb_state_e;

    // Buffered lines may answer a read only while no memory read is in flight.
    function automatic logic can_forward(input wb_state_e st);
        return (st == ST_IDLE) || (st == ST_WR);
    endfunction

endpackage

// File: rtl/dcache_wb_buffer_entry_fifo.sv
// Age-ordered line store for the write-back buffer: push at tail, pop at head,
// in-place coalescing writes and a youngest-match lookup for forwarding.
module wb_entry_fifo #(
    parameter int DEPTH  = 2,
    parameter int TAG_W  = 27,
    parameter int LINE_W = 256,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [TAG_W-1:0]  push_tag_i,
    input  logic [LINE_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic              coal_we_i,
    input  logic [PTR_W-1:0]  coal_idx_i,
    input  logic [LINE_W-1:0] coal_data_i,
    input  logic              set_infl_i,
    input  logic [TAG_W-1:0]  lk_tag_i,
    output logic              coal_hit_o,
    output logic [PTR_W-1:0]  coal_idx_o,
    output logic              fwd_hit_o,
    output logic [LINE_W-1:0] fwd_data_o,
    output logic [PTR_W-1:0]  head_idx_o,
    output logic [TAG_W-1:0]  head_tag_o,
    output logic [LINE_W-1:0] head_data_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [DEPTH-1:0]  infl_q, infl_d;
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [TAG_W-1:0]  tag_d  [DEPTH];
    logic [LINE_W-1:0] data_q [DEPTH];
    logic [LINE_W-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W:0]    cnt_q, cnt_d;
    logic [PTR_W-1:0]  idx;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        coal_hit_o = 1'b0;
        coal_idx_o = '0;
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        idx        = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + k[PTR_W-1:0];
            if (vld_q[idx] && (tag_q[idx] == lk_tag_i)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = data_q[idx];
                if (!infl_q[idx]) begin
                    coal_hit_o = 1'b1;
                    coal_idx_o = idx;
                end
            end
        end
    end

    always_comb begin
        vld_d  = vld_q;
        infl_d = infl_q;
        tag_d  = tag_q;
        data_d = data_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q + (PTR_W+1)'(push_i) - (PTR_W+1)'(pop_i);
        if (set_infl_i) begin
            infl_d[head_q] = 1'b1;
        end
        if (coal_we_i) begin
            data_d[coal_idx_i] = coal_data_i;
        end
        if (pop_i) begin
            vld_d[head_q]  = 1'b0;
            infl_d[head_q] = 1'b0;
            head_d         = head_q + PTR_W'(1);
        end
        // Push after pop: when full, the tail slot is the head being retired.
        if (push_i) begin
            vld_d[tail_q]  = 1'b1;
            infl_d[tail_q] = 1'b0;
            tag_d[tail_q]  = push_tag_i;
            data_d[tail_q] = push_data_i;
            tail_d         = tail_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_q  <= '0;
            infl_q <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            infl_q <= infl_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign head_idx_o  = head_q;
    assign head_tag_o  = tag_q[head_q];
    assign head_data_o = data_q[head_q];
    assign full_o      = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o     = (cnt_q == '0);

endmodule

// File: rtl/dcache_wb_buffer.sv
// Write-back buffer between the dcache memory port and Data_Memory: absorbs
// evictions, forwards buffered lines to refills and drains when memory is idle.
module dcache_wb_buffer
    import dcache_wb_buffer_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = REG_LEN,
    parameter int LINE_W = DM_UNIT_MASK + 1,
    parameter int OFS_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              up_enable_i,
    input  logic              up_write_i,
    input  logic [ADDR_W-1:0] up_addr_i,
    input  logic [LINE_W-1:0] up_data_i,
    output logic              up_ack_o,
    output logic [LINE_W-1:0] up_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_data_i
);

    localparam int TAG_W = ADDR_W - OFS_W;
    localparam int PTR_W = $clog2(DEPTH);

    wb_state_e         state_q, state_d;
    logic              up_ack_q, up_ack_d;
    logic [LINE_W-1:0] up_data_q, up_data_d;
    logic              mem_enable_q, mem_enable_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_data_q, mem_data_d;

    logic              rd_req, wr_req, rd_hit, wr_coal, wr_push, pop, set_infl;
    logic              coal_hit, fwd_hit, full, empty;
    logic [PTR_W-1:0]  coal_idx, head_idx;
    logic [TAG_W-1:0]  req_tag, head_tag;
    logic [LINE_W-1:0] fwd_data, head_data;
    logic              unused_ofs;

    assign req_tag    = up_addr_i[ADDR_W-1:OFS_W];
    assign unused_ofs = ^up_addr_i[OFS_W-1:0];

    // The ack cycle still presents the finished request, so it is masked out.
    assign rd_req  = up_enable_i & ~up_write_i & ~up_ack_q;
    assign wr_req  = up_enable_i &  up_write_i & ~up_ack_q;
    assign pop     = (state_q == ST_WR) & mem_ack_i;
    assign wr_coal = wr_req & coal_hit;
    assign wr_push = wr_req & ~coal_hit & (~full | pop);
    assign rd_hit  = rd_req & fwd_hit & can_forward(state_q);

    wb_entry_fifo #(
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W),
        .LINE_W (LINE_W),
        .PTR_W  (PTR_W)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (wr_push),
        .push_tag_i  (req_tag),
        .push_data_i (up_data_i),
        .pop_i       (pop),
        .coal_we_i   (wr_coal),
        .coal_idx_i  (coal_idx),
        .coal_data_i (up_data_i),
        .set_infl_i  (set_infl),
        .lk_tag_i    (req_tag),
        .coal_hit_o  (coal_hit),
        .coal_idx_o  (coal_idx),
        .fwd_hit_o   (fwd_hit),
        .fwd_data_o  (fwd_data),
        .head_idx_o  (head_idx),
        .head_tag_o  (head_tag),
        .head_data_o (head_data),
        .full_o      (full),
        .empty_o     (empty)
    );

    always_comb begin
        state_d      = state_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        up_ack_d     = wr_coal | wr_push | rd_hit;
        up_data_d    = up_data_q;
        set_infl     = 1'b0;
        if (rd_hit) begin
            up_data_d = fwd_data;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (rd_req && !fwd_hit) begin
                    state_d      = ST_RD;
                    mem_enable_d = 1'b1;
                    mem_write_d  = 1'b0;
                    mem_addr_d   = {req_tag, {OFS_W{1'b0}}};
                end else if (!empty) begin
                    state_d      = ST_WR;
                    mem_enable_d = 1'b1;
                    mem_write_d  = 1'b1;
                    mem_addr_d   = {head_tag, {OFS_W{1'b0}}};
                    set_infl     = 1'b1;
                    // A same-edge coalesce into the head must reach memory too.
                    mem_data_d   = (wr_coal && (coal_idx == head_idx)) ? up_data_i : head_data;
                end
            end
            ST_RD: begin
                if (mem_ack_i) begin
                    state_d      = ST_RESP;
                    mem_enable_d = 1'b0;
                    up_ack_d     = 1'b1;
                    up_data_d    = mem_data_i;
                end
            end
            ST_WR: begin
                if (mem_ack_i) begin
                    state_d      = ST_IDLE;
                    mem_enable_d = 1'b0;
                    mem_write_d  = 1'b0;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            up_ack_q     <= 1'b0;
            up_data_q    <= '0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            up_ack_q     <= up_ack_d;
            up_data_q    <= up_data_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
        end
    end

    assign up_ack_o     = up_ack_q;
    assign up_data_o    = up_data_q;
    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Bench for dcache_wb_buffer: directed vectors, multi-cycle corner sequences and
// a randomized run against a line-level memory-ordering model.
module tb_dcache_wb_buffer;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              up_enable_i = 1'b0;
    logic              up_write_i = 1'b0;
    logic [ADDR_W-1:0] up_addr_i = '0;
    logic [LINE_W-1:0] up_data_i = '0;
    logic              up_ack_o;
    logic [LINE_W-1:0] up_data_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic              mem_ack_i;
    logic [LINE_W-1:0] mem_data_i;

    dcache_wb_buffer #(
        .DEPTH  (2),
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W),
        .OFS_W  (5)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .up_enable_i  (up_enable_i),
        .up_write_i   (up_write_i),
        .up_addr_i    (up_addr_i),
        .up_data_i    (up_data_i),
        .up_ack_o     (up_ack_o),
        .up_data_o    (up_data_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_ack_i    (mem_ack_i),
        .mem_data_i   (mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [255:0] data;
        int          s_cyc;
        int          a_cyc;
    } txn_t;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] rdata;
        int           lat;
    } vec_t;

    typedef struct {
        int           k;
        logic [255:0] d;
    } hist_t;

    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           mem_lat = 0;
    bit           rand_lat = 0;
    int           txn_starts = 0;
    int           last_ack_cyc = 0;
    logic [255:0] mem [int];
    txn_t         log_q [$];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mem_rd(input int k);
        if (mem.exists(k)) return mem[k];
        return '0;
    endfunction

    function automatic logic [255:0] rnd_line();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Memory responder: random or fixed latency, one-cycle ack pulse, logs every transaction.
    txn_t cur;
    bit   active;
    int   wait_cnt;
    initial begin
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        active     = 0;
        wait_cnt   = 0;
        forever begin
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            if (!rst_i) begin
                active = 0;
            end else if (mem_enable_o) begin
                if (!active) begin
                    active = 1;
                    txn_starts++;
                    wait_cnt   = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
                    cur.wr     = mem_write_o;
                    cur.addr   = mem_addr_o;
                    cur.data   = mem_data_o;
                    cur.s_cyc  = cyc;
                end
                if (wait_cnt == 0) begin
                    chk("mem_addr_stable", mem_addr_o, cur.addr);
                    chk("mem_write_stable", mem_write_o, cur.wr);
                    chk("mem_data_stable", mem_data_o, cur.data);
                    chk("mem_addr_aligned", mem_addr_o[4:0], 0);
                    cur.a_cyc = cyc;
                    log_q.push_back(cur);
                    if (cur.wr) mem[int'(cur.addr >> 5)] = cur.data;
                    else        mem_data_i = mem_rd(int'(cur.addr >> 5));
                    mem_ack_i = 1'b1;
                    active    = 0;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    task automatic do_req(input bit wr, input logic [31:0] a, input logic [255:0] d,
                          output int lat, output logic [255:0] rd);
        @(posedge clk_i); #1;
        up_enable_i = 1'b1;
        up_write_i  = wr;
        up_addr_i   = a;
        up_data_i   = d;
        lat = 0;
        while (lat < 300) begin
            @(posedge clk_i);
            lat++;
            @(negedge clk_i);
            if (up_ack_o) break;
        end
        chk("up_ack_seen", up_ack_o, 1);
        last_ack_cyc = cyc;
        rd = up_data_o;
        @(posedge clk_i); #1;
        up_enable_i = 1'b0;
        up_write_i  = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget);
        for (int t = 0; t < budget && log_q.size() < n; t++) @(negedge clk_i);
        chk("log_wait", log_q.size() >= n, 1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_up_ack"}, up_ack_o, 0);
        chk({tag, "_up_data"}, up_data_o, 0);
        chk({tag, "_mem_en"}, mem_enable_o, 0);
        chk({tag, "_mem_wr"}, mem_write_o, 0);
        chk({tag, "_mem_addr"}, mem_addr_o, 0);
        chk({tag, "_mem_data"}, mem_data_o, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t         tbl [8];
    hist_t        hist_q [$];
    logic [255:0] shadow [4];
    int           pos [4];
    int           lat, mark, starts, idle_run, k, rstart, j;
    logic [31:0]  a;
    logic [255:0] d, rd, A, B, C, SEED;
    bit           found;

    initial begin
        A    = {8{32'hAAAA_0001}};
        B    = {8{32'hBBBB_0002}};
        C    = {8{32'hCCCC_0003}};
        SEED = {8{32'h5EED_1234}};
        mem[int'(32'h1060 >> 5)] = SEED;

        tbl[0] = '{1, 32'h1000, {8{32'hD1D1_0000}}, '0, 1};
        tbl[1] = '{0, 32'h1000, '0, {8{32'hD1D1_0000}}, 0};
        tbl[2] = '{1, 32'h1020, {8{32'hD2D2_0000}}, '0, 1};
        tbl[3] = '{1, 32'h1024, {8{32'hD3D3_0000}}, '0, 1};
        tbl[4] = '{0, 32'h103C, '0, {8{32'hD3D3_0000}}, 0};
        tbl[5] = '{0, 32'h1040, '0, '0, 0};
        tbl[6] = '{0, 32'h1068, '0, {8{32'h5EED_1234}}, 0};
        tbl[7] = '{0, 32'h1004, '0, {8{32'hD1D1_0000}}, 0};

        repeat (2) @(negedge clk_i);
        chk_outputs_zero("reset");
        @(posedge clk_i); #1;
        rst_i = 1'b1;

        // Table-driven vectors.
        mem_lat = 1;
        for (int i = 0; i < 8; i++) begin
            do_req(tbl[i].wr, tbl[i].addr, tbl[i].wdata, lat, rd);
            if (tbl[i].wr) chk($sformatf("vec%0d_wr_lat", i), lat, tbl[i].lat);
            else           chk($sformatf("vec%0d_rd_data", i), rd, tbl[i].rdata);
        end
        repeat (15) @(negedge clk_i);

        // Single write then drain.
        mem_lat = 2;
        mark = log_q.size();
        do_req(1, 32'h400, A, lat, rd);
        chk("t1_wr_lat", lat, 1);
        wait_log(mark + 1, 50);
        chk("t1_mem_wr", log_q[mark].wr, 1);
        chk("t1_mem_addr", log_q[mark].addr, 32'h400);
        chk("t1_mem_data", log_q[mark].data, A);
        chk("t1_memory32", mem_rd(32), A);
        repeat (10) @(negedge clk_i);
        chk("t1_no_extra_traffic", log_q.size(), mark + 1);

        // Read hit on a still-buffered line.
        mem_lat = 12;
        mark = log_q.size();
        do_req(1, 32'h400, B, lat, rd);
        do_req(0, 32'h400, '0, lat, rd);
        chk("t2_rd_data", rd, B);
        chk("t2_rd_lat", lat, 1);
        wait_log(mark + 1, 80);
        repeat (10) @(negedge clk_i);
        chk("t2_only_write", log_q.size(), mark + 1);
        chk("t2_is_write", log_q[mark].wr, 1);

        // Coalescing behind an inflight drain.
        mark = log_q.size();
        do_req(1, 32'h800, C, lat, rd);
        do_req(1, 32'h400, A, lat, rd);
        do_req(1, 32'h41C, B, lat, rd);
        chk("t3_coal_lat", lat, 1);
        wait_log(mark + 2, 150);
        repeat (12) @(negedge clk_i);
        chk("t3_two_writes", log_q.size(), mark + 2);
        chk("t3_first_addr", log_q[mark].addr, 32'h800);
        chk("t3_second_addr", log_q[mark+1].addr, 32'h400);
        chk("t3_second_data", log_q[mark+1].data, B);

        // Full-buffer stall released by the drain pop.
        mem_lat = 8;
        mark = log_q.size();
        do_req(1, 32'h400, A, lat, rd);
        do_req(1, 32'h800, B, lat, rd);
        do_req(1, 32'hC00, C, lat, rd);
        chk("t4_stalled", lat > 1, 1);
        wait_log(mark + 3, 200);
        chk("t4_ack_after_pop", last_ack_cyc, log_q[mark].a_cyc + 1);
        chk("t4_order0", log_q[mark].addr, 32'h400);
        chk("t4_order1", log_q[mark+1].addr, 32'h800);
        chk("t4_order2", log_q[mark+2].addr, 32'hC00);
        chk("t4_data2", log_q[mark+2].data, C);
        repeat (12) @(negedge clk_i);

        // Read miss arriving during a drain.
        mem_lat = 4;
        mark = log_q.size();
        do_req(1, 32'h400, A, lat, rd);
        do_req(0, 32'h020, '0, lat, rd);
        wait_log(mark + 2, 10);
        chk("t5_first_is_write", log_q[mark].wr, 1);
        chk("t5_read_issued", log_q[mark+1].wr, 0);
        chk("t5_read_addr", log_q[mark+1].addr, 32'h020);
        chk("t5_read_start", log_q[mark+1].s_cyc, log_q[mark].a_cyc + 2);
        chk("t5_read_data", rd, mem_rd(1));
        chk("t5_resp_cycle", last_ack_cyc, log_q[mark+1].a_cyc + 1);
        repeat (12) @(negedge clk_i);

        // Reset in the middle of a drain with two entries buffered.
        mem_lat = 30;
        do_req(1, 32'h1400, A, lat, rd);
        do_req(1, 32'h1800, B, lat, rd);
        @(negedge clk_i);
        chk("t6_in_wr", mem_enable_o & mem_write_o, 1);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        #1;
        chk_outputs_zero("t6_async");
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        starts = txn_starts;
        repeat (15) @(negedge clk_i);
        chk("t6_no_traffic", txn_starts, starts);
        mem_lat = 1;
        do_req(0, 32'h1400, '0, lat, rd);
        chk("t6_buffer_flushed", rd, mem_rd(int'(32'h1400 >> 5)));
        repeat (10) @(negedge clk_i);

        // Randomized run against a line-level model.
        rand_lat = 1;
        rstart   = cyc;
        for (int i = 0; i < 4; i++) begin
            shadow[i] = mem_rd(int'((32'h2_0000 >> 5)) + i);
            pos[i] = 0;
        end
        for (int n = 0; n < 250; n++) begin
            k = $urandom_range(0, 3);
            a = 32'h2_0000 + 32'(k * 32) + 32'($urandom_range(0, 7) * 4);
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
            if ($urandom_range(0, 1) == 1) begin
                d = rnd_line();
                do_req(1, a, d, lat, rd);
                shadow[k] = d;
                hist_q.push_back('{k, d});
            end else begin
                do_req(0, a, '0, lat, rd);
                chk($sformatf("rand_rd_%0d", n), rd, shadow[k]);
            end
        end
        idle_run = 0;
        for (int t = 0; t < 400 && idle_run < 12; t++) begin
            @(negedge clk_i);
            idle_run = mem_enable_o ? 0 : idle_run + 1;
        end
        chk("rand_drained", idle_run >= 12, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rand_final_line%0d", i), mem_rd(int'((32'h2_0000 >> 5)) + i), shadow[i]);
        end
        foreach (log_q[i]) begin
            if (log_q[i].wr && log_q[i].s_cyc >= rstart) begin
                k = int'((log_q[i].addr - 32'h2_0000) >> 5);
                found = 0;
                if (k >= 0 && k < 4) begin
                    for (j = pos[k]; j < hist_q.size(); j++) begin
                        if (hist_q[j].k == k && hist_q[j].d == log_q[i].data) begin
                            found = 1;
                            break;
                        end
                    end
                    if (found) pos[k] = j;
                end
                chk($sformatf("rand_write_order_%0d", i), found, 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_wb_buffer.md
Name: dcache_wb_buffer

Overview:
- Write-back buffer between the dcache memory port and Data_Memory; drop-in on the cpu_mem_* / mem_cpu_* nets.
- Absorbs dirty-line evictions so the refill read reaches memory first, with a 1-cycle ack to the cache.
- Forwards buffered lines to cache reads, which keeps memory ordering correct.
- Drains buffered writes to Data_Memory whenever the memory port is idle.

Parameters:
- DEPTH, 2: number of line entries (power of 2, ≥2).
- ADDR_W, 32: address width (`REG_LEN).
- LINE_W, 256: line width (`DM_UNIT_MASK+1).
- OFS_W, 5: byte-offset bits in a line; line address is addr[ADDR_W-1:OFS_W].

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset (0 = reset)
- up_enable_i  in  1  cache request valid; held until up_ack_o
- up_write_i  in  1  1 = line write (eviction), 0 = line read (refill)
- up_addr_i  in  ADDR_W  request address
- up_data_i  in  LINE_W  write line
- up_ack_o  out  1  one-cycle completion pulse
- up_data_o  out  LINE_W  read line, valid while up_ack_o=1
- mem_enable_o  out  1  memory request; held until mem_ack_i
- mem_write_o  out  1  memory write select
- mem_addr_o  out  ADDR_W  line-aligned address (low OFS_W bits 0)
- mem_data_o  out  LINE_W  write line
- mem_ack_i  in  1  memory completion pulse
- mem_data_i  in  LINE_W  memory read line

Behaviour:
- Reset (async, rst_i=0): all outputs 0, all entries invalid, count=0, state=IDLE. Reset mid-transfer discards buffered data; the memory transaction is abandoned.
- All outputs are registered. Memory signals stay stable while mem_enable_o=1.
- No new request is accepted in a cycle where up_ack_o=1; that cycle still shows the old request.
- Entries are a FIFO ordered by age. Each entry holds valid, line address, data and an inflight flag.
- Write, buffer not full:
  - Accepted at the clock edge.
  - up_ack_o=1 the next cycle.
  - Coalescing: if a valid, not-inflight entry has the same line address, its data is overwritten and no slot is allocated. Otherwise the line is pushed at the tail.
- Write, buffer full with no coalesce target: stalls (no ack) until a drain pop frees a slot. The write is accepted on the pop edge itself.
- Read:
  - Lookup compares the line address against all valid entries; the youngest match wins.
  - Hit: up_data_o = entry data and up_ack_o=1 the next cycle; memory is untouched.
  - Miss: memory read at the line address; mem_data_i is registered on mem_ack_i; up_ack_o and up_data_o follow one cycle later.
  - Lookup is repeated every cycle while the read is pending, since a drain may retire the match.
- FSM:
  - IDLE, pending read miss → RD: issue mem read.
  - IDLE, otherwise count>0 → WR: issue mem write of the head entry and set its inflight flag.
  - RD → on mem_ack_i → RESP.
  - WR → on mem_ack_i → IDLE and pop the head.
  - RESP → IDLE (up_ack_o pulses).
- Priority and ordering:
  - A read miss beats draining.
  - A read miss arriving during WR waits for mem_ack_i; the read issues the cycle after.
  - mem_enable_o drops for exactly one cycle between memory transactions.
- Simultaneous events:
  - Write accept with drain pop in the same cycle: count is unchanged.
  - A write to the line that is inflight allocates a new entry, so two entries share the address and forwarding picks the younger.
- Ordering guarantee: memory receives writes in acceptance order. A read never returns data older than the latest accepted write to that line.

Decomposition:
- Shared defines: use the existing `REG_LEN and `DM_UNIT_MASK for widths.
- State encoding localparams (IDLE/RD/WR/RESP) go in the shared cache definitions header.
- One sub-module, wb_entry_fifo:
  - DEPTH-entry storage with push, pop and coalesce-write ports.
  - Youngest-match lookup that excludes inflight entries for coalescing but includes them for forwarding.
  - Full and empty outputs.

Test Plan:
- Write 0x00000400 with data A → up_ack_o 1 cycle later. Then the drain shows mem_write_o=1, mem_addr_o=0x400, mem_data_o=A. Memory[32]=A after mem_ack_i; count returns to 0.
- Write 0x400=A, then read 0x400 before the drain completes → up_data_o=A, with no mem read issued while the line is still buffered.
- Write 0x400=A then 0x41C=B (same line, not inflight) → one entry with data B; only one memory write occurs.
- Write 0x400, 0x800, then write 0xC00 with DEPTH=2 → 0xC00 acked only after the first drain pop. Memory write order is 0x400, 0x800, 0xC00.
- Read miss 0x020 issued during the drain of 0x400 → mem read of 0x020 starts the cycle after the write's mem_ack_i. up_data_o = memory[1] = 0 (the data mem_data_i returned with the read's mem_ack_i), one cycle after that mem_ack_i.
- Assert rst_i=0 mid-WR with 2 entries → all outputs 0 immediately, count=0. After release, no memory traffic until a new request arrives.
